// File: rtl/key_beep_ctrl.sv
// Multi-key buzzer controller: debounced key presses; key 0 toggles a continuous tone, key k plays k beeps.
// Optional macro BUZ_DC_EN: drive buz as a constant 1 while sounding (active buzzer), no tone counter.
module key_beep_ctrl #(
  parameter int unsigned NUM_KEYS      = 4,
  parameter int unsigned DEB_CYC       = 1000000,
  parameter int unsigned TONE_HALF_CYC = 12500,
  parameter int unsigned BEEP_CYC      = 5000000,
  parameter int unsigned GAP_CYC       = 5000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_evt,
  output logic                buz,
  output logic                busy
);

  localparam int unsigned DEB_W  = $clog2(DEB_CYC + 1);
  localparam int unsigned PH_MAX = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
  localparam int unsigned TMR_W  = $clog2(PH_MAX + 1);
  localparam int unsigned REM_W  = $clog2(NUM_KEYS);
`ifndef BUZ_DC_EN
  localparam int unsigned TONE_W = $clog2(TONE_HALF_CYC + 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_CONT, S_ON, S_OFF} state_t;

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] r_deb;
  logic [NUM_KEYS-1:0] r_key_evt;
  logic [DEB_W-1:0]    r_deb_cnt [NUM_KEYS];

  state_t              r_state;
  logic [REM_W-1:0]    r_rem;
  logic [TMR_W-1:0]    r_tmr;
  logic                r_buz;
  logic                r_busy;
`ifndef BUZ_DC_EN
  logic [TONE_W-1:0]   r_tone_cnt;
`endif

  logic                w_any;
  logic [REM_W-1:0]    w_sel;
  state_t              w_state_nxt;
  logic [REM_W-1:0]    w_rem_nxt;
  logic                w_restart;
  logic                w_phase_new;
  logic                w_tone_nxt;

  assign key_evt = r_key_evt;
  assign buz     = r_buz;
  assign busy    = r_busy;

  // Synchronise, then accept a level once it has differed from the debounced state for DEB_CYC cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1   <= '1;
      r_sync2   <= '1;
      r_deb     <= '1;
      r_key_evt <= '0;
      for (int i = 0; i < int'(NUM_KEYS); i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        r_key_evt[i] <= 1'b0;
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_W'(DEB_CYC - 1)) begin
          r_deb_cnt[i] <= '0;
          r_deb[i]     <= r_sync2[i];
          r_key_evt[i] <= r_deb[i];
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Lowest-index event wins when several keys are accepted together
  always_comb begin
    w_any = |r_key_evt;
    w_sel = '0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (r_key_evt[i]) w_sel = REM_W'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_restart   = 1'b0;
    if (w_any) begin
      if (w_sel == '0) begin
        w_state_nxt = (r_state == S_CONT) ? S_IDLE : S_CONT;
      end else begin
        w_state_nxt = S_ON;
        w_rem_nxt   = w_sel;
        w_restart   = 1'b1;
      end
    end else begin
      unique case (r_state)
        S_ON: begin
          if (r_tmr == TMR_W'(BEEP_CYC - 1)) begin
            if (r_rem > REM_W'(1)) begin
              w_state_nxt = S_OFF;
              w_rem_nxt   = r_rem - REM_W'(1);
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_OFF: begin
          if (r_tmr == TMR_W'(GAP_CYC - 1)) w_state_nxt = S_ON;
        end
        default: ;
      endcase
    end
    w_phase_new = w_restart || (w_state_nxt != r_state);
    w_tone_nxt  = (w_state_nxt == S_ON) || (w_state_nxt == S_CONT);
  end

  // State, phase timer and buzzer drive; every phase entry restarts timer and tone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_tmr      <= '0;
      r_buz      <= 1'b0;
      r_busy     <= 1'b0;
`ifndef BUZ_DC_EN
      r_tone_cnt <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      if (!w_phase_new && ((w_state_nxt == S_ON) || (w_state_nxt == S_OFF))) begin
        r_tmr <= r_tmr + TMR_W'(1);
      end else begin
        r_tmr <= '0;
      end
`ifdef BUZ_DC_EN
      r_buz <= w_tone_nxt;
`else
      if (!w_tone_nxt) begin
        r_buz      <= 1'b0;
        r_tone_cnt <= '0;
      end else if (w_phase_new) begin
        r_buz      <= 1'b1;
        r_tone_cnt <= '0;
      end else if (r_tone_cnt == TONE_W'(TONE_HALF_CYC - 1)) begin
        r_buz      <= ~r_buz;
        r_tone_cnt <= '0;
      end else begin
        r_tone_cnt <= r_tone_cnt + TONE_W'(1);
      end
`endif
    end
  end

endmodule
